// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable scheduler: FSM encoding,
// default ratio width and requester indices.
package clk_div_pkg;

    localparam int CLK_DIV_W = 8;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/clk_div_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer selects the winner only on a tie.
module rr_arb2
    import clk_div_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Synchronous clock-enable divider with a runtime ratio that two requesters
// can change; new ratios take effect only at an enable-period boundary.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = CLK_DIV_W,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [DIV_W-1:0] req0_div,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DIV_W-1:0] req1_div,
    output logic             req1_ready,
    input  logic             stop,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy,
    output logic             change_done
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             change_done_q, change_done_d;
    logic [1:0]       grant;
    logic [DIV_W-1:0] grant_div;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // cur_div is never zero, so N-1 cannot wrap.
    assign clk_en      = !reset && !stop && (cnt_q == cur_div_q - ONE);
    assign cur_div     = cur_div_q;
    assign busy        = (state_q == ST_PEND);
    assign change_done = change_done_q;
    assign grant_div   = grant[REQ1] ? req1_div : req0_div;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_div_d     = cur_div_q;
        pend_div_d    = pend_div_q;
        rr_ptr_d      = rr_ptr_q;
        change_done_d = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        if (!stop) begin
            cnt_d = clk_en ? '0 : cnt_q + ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!reset && (grant != 2'b00)) begin
                    req0_ready = grant[REQ0];
                    req1_ready = grant[REQ1];
                    pend_div_d = (grant_div == '0) ? ONE : grant_div;
                    rr_ptr_d   = grant[REQ0];
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (clk_en) begin
                    cur_div_d     = pend_div_q;
                    cnt_d         = '0;
                    change_done_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cur_div_q     <= DEF_DIV;
            pend_div_q    <= '0;
            rr_ptr_q      <= 1'b0;
            change_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_div_q     <= cur_div_d;
            pend_div_q    <= pend_div_d;
            rr_ptr_q      <= rr_ptr_d;
            change_done_q <= change_done_d;
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios followed by random traffic,
// every cycle compared against a countdown-based reference model.
module tb_clk_div_sched;

    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0;
    logic [DIV_W-1:0] req0_div = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [DIV_W-1:0] req1_div = '0;
    logic             req1_ready;
    logic             stop = 1'b0;
    logic             clk_en;
    logic [DIV_W-1:0] cur_div;
    logic             busy;
    logic             change_done;

    int checks = 0;
    int errors = 0;

    // reference model: cycles left until the next enable, ratio, pending change
    int m_left, m_div, m_pdiv, m_pref;
    bit m_pend, m_done;

    // outputs observed in the most recent cycle
    logic o_en, o_done, o_r0, o_r1;

    always #5 clk = ~clk;

    clk_div_sched #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_div    (req0_div),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_div    (req1_div),
        .req1_ready  (req1_ready),
        .stop        (stop),
        .clk_en      (clk_en),
        .cur_div     (cur_div),
        .busy        (busy),
        .change_done (change_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = DEFAULT_DIV;
        m_div  = DEFAULT_DIV;
        m_pdiv = 0;
        m_pref = 0;
        m_pend = 0;
        m_done = 0;
    endtask

    // One clock cycle: inputs are already set; compare mid-cycle, advance model.
    task automatic cyc();
        int g;
        bit e_en, p;
        @(negedge clk);
        g = -1;
        if (req0_valid && req1_valid) g = m_pref;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        e_en = !stop && (m_left == 1);
        chk("clk_en", 32'(clk_en), 32'(e_en));
        chk("cur_div", 32'(cur_div), 32'(m_div));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("change_done", 32'(change_done), 32'(m_done));
        chk("req0_ready", 32'(req0_ready), 32'(!m_pend && g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(!m_pend && g == 1));
        o_en = clk_en; o_done = change_done; o_r0 = req0_ready; o_r1 = req1_ready;

        p = m_pend;
        m_done = 0;
        if (!p && g >= 0) begin
            m_pend = 1;
            m_pdiv = (g == 0) ? int'(req0_div) : int'(req1_div);
            if (m_pdiv == 0) m_pdiv = 1;
            m_pref = 1 - g;
        end
        if (e_en) begin
            if (p) begin
                m_div  = m_pdiv;
                m_pend = 0;
                m_done = 1;
            end
            m_left = m_div;
        end else if (!stop) begin
            m_left--;
        end
        @(posedge clk);
        #1;
        if (!p && g == 0) req0_valid = 1'b0;
        if (!p && g == 1) req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        stop = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();

        // free-running enable at the default ratio
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("dflt_en_cycle", 32'(o_en), 32'(c % 4 == 0));
        end
        chk("dflt_busy", 32'(busy), 32'(0));

        // req0 div=3 presented in cycle 2
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin req0_valid = 1'b1; req0_div = 8'd3; end
            cyc();
            if (c == 2) chk("r0_ready_c2", 32'(o_r0), 32'(1));
            chk("d3_done_cycle", 32'(o_done), 32'(c == 5));
            chk("d3_en_cycle", 32'(o_en), 32'(c == 4 || c == 7 || c == 10));
        end
        chk("d3_cur_div", 32'(cur_div), 32'(3));

        // both valid: req0 first, then req1 after the pointer moves
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                req0_valid = 1'b1; req0_div = 8'd2;
                req1_valid = 1'b1; req1_div = 8'd6;
            end
            if (c == 5) begin req0_valid = 1'b1; req0_div = 8'd2; end
            if (c == 6) req0_valid = 1'b0;
            cyc();
            if (c == 1) chk("rr_first_r0", 32'({o_r1, o_r0}), 32'(2'b01));
            if (c == 5) chk("rr_second_r1", 32'({o_r1, o_r0}), 32'(2'b10));
        end
        chk("rr_final_div", 32'(cur_div), 32'(6));

        // req1 div=0 becomes ratio 1: enable continuously high
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin req1_valid = 1'b1; req1_div = 8'd0; end
            cyc();
            if (c >= 5) chk("div1_en_high", 32'(o_en), 32'(1));
        end
        chk("div1_cur_div", 32'(cur_div), 32'(1));

        // accept coinciding with an enable waits for the following boundary
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) begin req0_valid = 1'b1; req0_div = 8'd5; end
            cyc();
            if (c == 4) chk("coinc_accept", 32'({o_en, o_r0}), 32'(2'b11));
            chk("coinc_done_cycle", 32'(o_done), 32'(c == 9));
        end

        // stop held while a change is pending
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) begin req0_valid = 1'b1; req0_div = 8'd2; end
            stop = (c >= 2 && c <= 11);
            cyc();
            if (c >= 2 && c <= 11) chk("stop_en_low", 32'(o_en), 32'(0));
            chk("stop_done_cycle", 32'(o_done), 32'(c == 15));
        end
        chk("stop_cur_div", 32'(cur_div), 32'(2));

        // asynchronous reset pulse mid-PEND discards the pending ratio
        do_reset();
        req0_valid = 1'b1; req0_div = 8'd7;
        cyc();
        req1_valid = 1'b1; req1_div = 8'd3;
        #2 reset = 1'b1;
        #1;
        chk("arst_cur_div", 32'(cur_div), 32'(DEFAULT_DIV));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_en", 32'(clk_en), 32'(0));
        chk("arst_ready", 32'({req1_ready, req0_ready}), 32'(0));
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            chk("arst_no_done", 32'(o_done), 32'(0));
        end
        chk("arst_div_kept", 32'(cur_div), 32'(DEFAULT_DIV));

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!req0_valid && ($urandom % 4 == 0)) begin
                req0_valid = 1'b1; req0_div = DIV_W'($urandom % 6);
            end
            if (!req1_valid && ($urandom % 4 == 0)) begin
                req1_valid = 1'b1; req1_div = DIV_W'($urandom % 6);
            end
            stop = ($urandom % 10 == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
